pci_master_req: RTL and testbench

//  Initiator-side bus-ownership controller for one PCI agent; the other end of pci_arbiter's REQn/GNTn pair.

---
 rtl/pci_master_req_pkg.sv | 18 +
 rtl/pci_master_req_if.sv | 31 +++
 rtl/pci_master_req_lat_timer.sv | 27 ++
 rtl/pci_master_req.sv | 135 +++++++++++++
 tb/tb_pci_master_req.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pci_master_req_pkg.sv
// Shared definitions for the PCI initiator bus-ownership controller.
// Optional latency-timer preemption is built when PCI_LAT_TIMER_EN is defined.
package pci_master_req_pkg;

    // Controller states: IDLE -> REQ -> ADDR -> DATA -> TURN -> IDLE
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAddr,
        StData,
        StTurn
    } state_e;

    // PCI control lines are active low
    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

endpackage

// File: rtl/pci_master_req_if.sv
// Local-side burst handshake plus PCI arbitration/control lines of one initiator.
// master: the controller's view; slave: the local requester / bus environment.
interface pci_master_req_if #(
    parameter int unsigned LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             preempted;
    logic [LEN_W-1:0] remaining;
    logic             data_ack;
    logic             ad_oe;
    logic             REQ_n;
    logic             GNT_n;
    logic             FRAME_n;
    logic             IRDY_n;
    logic             FRAME_n_in;
    logic             IRDY_n_in;
    logic             TRDY_n;

    modport master (
        input  start, len, GNT_n, FRAME_n_in, IRDY_n_in, TRDY_n,
        output busy, done, preempted, remaining, data_ack, ad_oe, REQ_n, FRAME_n, IRDY_n
    );

    modport slave (
        output start, len, GNT_n, FRAME_n_in, IRDY_n_in, TRDY_n,
        input  busy, done, preempted, remaining, data_ack, ad_oe, REQ_n, FRAME_n, IRDY_n
    );
endinterface

// File: rtl/pci_master_req_lat_timer.sv
// Latency timer: loaded during the address phase, counts down once per data cycle,
// saturates at zero. Only instantiated when PCI_LAT_TIMER_EN is defined.
module pci_lat_timer #(
    parameter int unsigned LAT_TIMER = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    // high when the timer is at or reaches zero at the end of this data cycle
    output logic expiring
);
    logic [7:0] count_q;

    // Load / saturating down-count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else if (load) begin
            count_q <= 8'(LAT_TIMER);
        end else if (dec && (count_q != 8'd0)) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign expiring = dec && (count_q <= 8'd1);
endmodule

// File: rtl/pci_master_req.sv
// PCI initiator bus-ownership controller: requests the bus, waits for grant and idle bus,
// runs the address phase and counts TRDY#-completed data phases until the burst ends.
// Define PCI_LAT_TIMER_EN to enable latency-timer preemption of long bursts.
module pci_master_req
    import pci_master_req_pkg::*;
#(
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned LAT_TIMER = 8
) (
    input logic             clk,
    input logic             reset,
    pci_master_req_if.master bus
);
    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] remaining_q;
    logic             req_n_q, frame_n_q, irdy_n_q, ad_oe_q;
    logic             busy_q, done_q, preempted_q, data_ack_q;

    logic             cnt_is_one;
    logic [LEN_W-1:0] cnt_dec;
    logic             cut;

    assign cnt_is_one = (cnt_q == LEN_W'(1));
    assign cnt_dec    = cnt_q - LEN_W'(1);

`ifdef PCI_LAT_TIMER_EN
    logic timer_load, timer_dec, expiring;

    assign timer_load = (state_q == StAddr);
    assign timer_dec  = (state_q == StData);

    pci_lat_timer #(
        .LAT_TIMER (LAT_TIMER)
    ) u_lat_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .dec      (timer_dec),
        .expiring (expiring)
    );

    // Timer ran out and grant was taken away: the phase after this one is the last
    assign cut = expiring && (bus.GNT_n == DEASSERTED);
`else
    // Timer length only matters when the latency timer is built in
    logic unused_lat_timer;
    assign unused_lat_timer = ^LAT_TIMER;
    assign cut = 1'b0;
`endif

    // Single FSM with all bus and status outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            remaining_q <= '0;
            req_n_q     <= DEASSERTED;
            frame_n_q   <= DEASSERTED;
            irdy_n_q    <= DEASSERTED;
            ad_oe_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            preempted_q <= 1'b0;
            data_ack_q  <= 1'b0;
        end else begin
            data_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && (bus.len != '0)) begin
                        cnt_q   <= bus.len;
                        req_n_q <= ASSERTED;
                        busy_q  <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if ((bus.GNT_n == ASSERTED) && (bus.FRAME_n_in == DEASSERTED) &&
                        (bus.IRDY_n_in == DEASSERTED)) begin
                        frame_n_q <= ASSERTED;
                        ad_oe_q   <= 1'b1;
                        if (cnt_is_one) req_n_q <= DEASSERTED;
                        state_q   <= StAddr;
                    end
                end
                StAddr: begin
                    irdy_n_q  <= ASSERTED;
                    frame_n_q <= cnt_is_one ? DEASSERTED : ASSERTED;
                    req_n_q   <= cnt_is_one ? DEASSERTED : ASSERTED;
                    state_q   <= StData;
                end
                StData: begin
                    if (bus.TRDY_n == ASSERTED) begin
                        data_ack_q <= 1'b1;
                        cnt_q      <= cnt_dec;
                        // FRAME# already high means this was the last phase
                        if (frame_n_q == DEASSERTED) begin
                            frame_n_q   <= DEASSERTED;
                            irdy_n_q    <= DEASSERTED;
                            req_n_q     <= DEASSERTED;
                            ad_oe_q     <= 1'b0;
                            done_q      <= 1'b1;
                            remaining_q <= cnt_dec;
                            preempted_q <= !cnt_is_one;
                            state_q     <= StTurn;
                        end else if ((cnt_dec == LEN_W'(1)) || cut) begin
                            frame_n_q <= DEASSERTED;
                            req_n_q   <= DEASSERTED;
                        end
                    end else if (cut) begin
                        frame_n_q <= DEASSERTED;
                        req_n_q   <= DEASSERTED;
                    end
                end
                StTurn: begin
                    done_q      <= 1'b0;
                    preempted_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.REQ_n     = req_n_q;
    assign bus.FRAME_n   = frame_n_q;
    assign bus.IRDY_n    = irdy_n_q;
    assign bus.ad_oe     = ad_oe_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.preempted = preempted_q;
    assign bus.remaining = remaining_q;
    assign bus.data_ack  = data_ack_q;
endmodule

// File: tb/tb_pci_master_req.sv
// Directed self-checking bench for pci_master_req. Inputs driven and outputs sampled on
// the falling clock edge. The preemption case runs only when PCI_LAT_TIMER_EN is defined.
module tb_pci_master_req;
    localparam int unsigned LEN_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    pci_master_req_if #(.LEN_W(LEN_W)) bus ();

    pci_master_req #(
        .LEN_W     (LEN_W),
        .LAT_TIMER (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start for one clock; returns on the first falling edge in REQ
    task automatic start_burst(input logic [LEN_W-1:0] l);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Follow a burst to its done pulse. pat supplies TRDY_n per data cycle (0 beyond pat_len).
    task automatic run_to_done(input string tag, input logic [15:0] pat, input int pat_len,
                               input bit drop_gnt, output int acks, output int addr_cyc,
                               output int frame_hi, output int rem, output int pre,
                               output bit irdy_ok);
        int i;
        bit data_seen;
        bit finished;
        i = 0;
        data_seen = 1'b0;
        finished = 1'b0;
        acks = 0;
        addr_cyc = -1;
        frame_hi = 0;
        rem = -1;
        pre = -1;
        irdy_ok = 1'b1;
        for (int c = 1; c <= 200 && !finished; c++) begin
            @(negedge clk);
            if (bus.data_ack) acks++;
            if (bus.done) begin
                finished = 1'b1;
                rem = int'(bus.remaining);
                pre = int'(bus.preempted);
            end else begin
                if (bus.FRAME_n == 1'b0 && bus.IRDY_n == 1'b1) begin
                    addr_cyc = c;
                    if (drop_gnt) bus.GNT_n = 1'b1;
                end
                if (bus.IRDY_n == 1'b0) begin
                    data_seen = 1'b1;
                    if (bus.FRAME_n) frame_hi++;
                    bus.TRDY_n = (i < pat_len) ? pat[i] : 1'b0;
                    i++;
                end else if (data_seen) begin
                    irdy_ok = 1'b0;
                end
            end
        end
        if (!finished) check_val({tag, " timeout"}, 0, 1);
    endtask

    initial begin
        int acks, ac, fh, rem, pre;
        bit ok;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.len = '0;
        bus.GNT_n = 1'b1;
        bus.FRAME_n_in = 1'b1;
        bus.IRDY_n_in = 1'b1;
        bus.TRDY_n = 1'b1;

        // T1: reset state held over several clocks
        repeat (3) @(negedge clk);
        check_val("rst REQ_n", bus.REQ_n, 1);
        check_val("rst FRAME_n", bus.FRAME_n, 1);
        check_val("rst IRDY_n", bus.IRDY_n, 1);
        check_val("rst ad_oe", bus.ad_oe, 0);
        check_val("rst busy", bus.busy, 0);
        check_val("rst done", bus.done, 0);
        check_val("rst data_ack", bus.data_ack, 0);
        check_val("rst remaining", bus.remaining, 0);
        check_val("rst preempted", bus.preempted, 0);
        reset = 1'b0;

        // len=0 is ignored
        start_burst(4'd0);
        check_val("len0 busy", bus.busy, 0);
        check_val("len0 REQ_n", bus.REQ_n, 1);

        // T2: len=3, grant and idle bus, target always ready
        bus.GNT_n = 1'b0;
        bus.TRDY_n = 1'b0;
        start_burst(4'd3);
        check_val("t2 busy", bus.busy, 1);
        check_val("t2 REQ_n", bus.REQ_n, 0);
        check_val("t2 FRAME_n in REQ", bus.FRAME_n, 1);
        run_to_done("t2", 16'h0000, 0, 1'b0, acks, ac, fh, rem, pre, ok);
        check_val("t2 acks", acks, 3);
        check_val("t2 addr cycle", ac, 1);
        check_val("t2 frame high phases", fh, 1);
        check_val("t2 remaining", rem, 0);
        check_val("t2 preempted", pre, 0);
        check_val("t2 irdy held", ok, 1);
        check_val("t2 turn ad_oe", bus.ad_oe, 0);
        check_val("t2 turn busy", bus.busy, 1);

        // Back-to-back: start with done ignored, then accepted in first IDLE cycle
        bus.start = 1'b1;
        bus.len = 4'd2;
        @(negedge clk);
        check_val("b2b busy low", bus.busy, 0);
        check_val("b2b done low", bus.done, 0);
        @(negedge clk);
        bus.start = 1'b0;
        check_val("b2b accepted", bus.busy, 1);
        run_to_done("b2b", 16'h0000, 0, 1'b0, acks, ac, fh, rem, pre, ok);
        check_val("b2b acks", acks, 2);

        // T3: bus busy with other master -> wait in REQ until FRAME# and IRDY# both high
        bus.FRAME_n_in = 1'b0;
        bus.IRDY_n_in = 1'b0;
        start_burst(4'd2);
        for (int k = 0; k < 4; k++) begin
            check_val("t3 FRAME_n held", bus.FRAME_n, 1);
            check_val("t3 REQ_n held", bus.REQ_n, 0);
            if (k == 2) bus.FRAME_n_in = 1'b1;
            if (k == 3) bus.IRDY_n_in = 1'b1;
            if (k < 3) @(negedge clk);
        end
        run_to_done("t3", 16'h0000, 0, 1'b0, acks, ac, fh, rem, pre, ok);
        check_val("t3 addr cycle", ac, 1);
        check_val("t3 acks", acks, 2);

        // T4: wait states, TRDY_n = 1,0,1,1,0,0,0
        start_burst(4'd4);
        run_to_done("t4", 16'h000D, 7, 1'b0, acks, ac, fh, rem, pre, ok);
        check_val("t4 acks", acks, 4);
        check_val("t4 irdy held", ok, 1);
        check_val("t4 frame high phases", fh, 1);
        check_val("t4 remaining", rem, 0);

        // Maximum length burst
        start_burst(4'd15);
        run_to_done("max", 16'h0000, 0, 1'b0, acks, ac, fh, rem, pre, ok);
        check_val("max acks", acks, 15);
        check_val("max remaining", rem, 0);

`ifdef PCI_LAT_TIMER_EN
        // T5: timer=2, grant removed after ADDR -> preempted after 3 phases
        start_burst(4'd8);
        run_to_done("t5", 16'h0000, 0, 1'b1, acks, ac, fh, rem, pre, ok);
        bus.GNT_n = 1'b0;
        check_val("t5 acks", acks, 3);
        check_val("t5 preempted", pre, 1);
        check_val("t5 remaining", rem, 5);
`endif

        // T6: reset in DATA releases the bus at once, no done; then a clean burst
        bus.TRDY_n = 1'b1;
        start_burst(4'd6);
        repeat (3) @(negedge clk);
        check_val("t6 in data", bus.IRDY_n, 0);
        #2 reset = 1'b1;
        #1;
        check_val("t6 async REQ_n", bus.REQ_n, 1);
        check_val("t6 async FRAME_n", bus.FRAME_n, 1);
        check_val("t6 async IRDY_n", bus.IRDY_n, 1);
        check_val("t6 async ad_oe", bus.ad_oe, 0);
        check_val("t6 async busy", bus.busy, 0);
        @(negedge clk);
        check_val("t6 no done", bus.done, 0);
        reset = 1'b0;
        bus.TRDY_n = 1'b0;
        start_burst(4'd1);
        check_val("t6 restart REQ_n", bus.REQ_n, 0);
        run_to_done("t6", 16'h0000, 0, 1'b0, acks, ac, fh, rem, pre, ok);
        check_val("t6 acks", acks, 1);
        check_val("t6 frame high phases", fh, 1);
        check_val("t6 remaining", rem, 0);
        check_val("t6 preempted", pre, 0);

        @(negedge clk);
        check_val("end busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
